// File: rtl/cpu8_pkg.sv
// Shared constants and types for the 8-bit CPU program path and its UART loader.
// UART_PARITY_EN (when defined) selects an 8E1 frame in the loader.
package cpu8_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef enum logic [2:0] {
    OP_HLT = 3'b000,
    OP_LDA = 3'b001,
    OP_STA = 3'b010,
    OP_ADD = 3'b011,
    OP_SUB = 3'b100,
    OP_JMP = 3'b101,
    OP_JZ  = 3'b110,
    OP_OUT = 3'b111
  } opcode_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } rx_state_t;

  // Opcode in the top bits, so an erased store halts the CPU.
  localparam logic [DATA_W-1:0] STORE_RESET = {OP_HLT, {(DATA_W-3){1'b0}}};

  function automatic logic even_parity_bit(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_program_loader_if.sv
// Loader <-> CPU/serial signal bundle. PE exists only when UART_PARITY_EN is defined.
// No handshake: RX is a free-running serial line, data_out is a combinational read of mem[PC].
interface uart_program_loader_if;
  import cpu8_pkg::*;

  logic              RX;
  logic              Load;
  logic [ADDR_W-1:0] PC;
  logic [DATA_W-1:0] data_out;
  logic              FE;
  logic [ADDR_W:0]   wr_count;
  logic              busy;
`ifdef UART_PARITY_EN
  logic              PE;

  modport master (output RX, Load, PC, input data_out, FE, wr_count, busy, PE);
  modport slave  (input RX, Load, PC, output data_out, FE, wr_count, busy, PE);
`else
  modport master (output RX, Load, PC, input data_out, FE, wr_count, busy);
  modport slave  (input RX, Load, PC, output data_out, FE, wr_count, busy);
`endif

endinterface

// File: rtl/uart_program_loader_rx_core.sv
// UART receiver: RX synchronizer, frame FSM and bit/clock counters.
// UART_PARITY_EN adds an even-parity bit between DATA and STOP.
module uart_rx_core
  import cpu8_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [DATA_W-1:0] rx_byte,
  output logic              byte_ok,
  output logic              frame_err,
`ifdef UART_PARITY_EN
  output logic              par_err,
`endif
  output rx_state_t         state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t         state_d;
  logic              rx_q, rx_s, rx_s_q;
  logic [CW-1:0]     clk_cnt, clk_cnt_d;
  logic [2:0]        bit_idx, bit_idx_d;
  logic [DATA_W-1:0] shift, shift_d;
  logic              fall;
`ifdef UART_PARITY_EN
  logic              par_bad, par_bad_d;
`endif

  assign fall    = rx_s_q & ~rx_s;
  assign rx_byte = shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      rx_q    <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_q  <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef UART_PARITY_EN
      par_bad <= 1'b0;
`endif
    end else begin
      state   <= state_d;
      rx_q    <= rx;
      rx_s    <= rx_q;
      rx_s_q  <= rx_s;
      clk_cnt <= clk_cnt_d;
      bit_idx <= bit_idx_d;
      shift   <= shift_d;
`ifdef UART_PARITY_EN
      par_bad <= par_bad_d;
`endif
    end
  end

  always_comb begin
    state_d   = state;
    clk_cnt_d = clk_cnt + 1'b1;
    bit_idx_d = bit_idx;
    shift_d   = shift;
    byte_ok   = 1'b0;
    frame_err = 1'b0;
`ifdef UART_PARITY_EN
    par_err   = 1'b0;
    par_bad_d = par_bad;
`endif
    case (state)
      IDLE: begin
        clk_cnt_d = '0;
        if (fall) begin
          state_d = START;
`ifdef UART_PARITY_EN
          par_bad_d = 1'b0;
`endif
        end
      end
      // A start bit that is high again at mid-bit was line noise.
      START: begin
        if (clk_cnt == HALF) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt == FULL) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift[DATA_W-1:1]};
          bit_idx_d = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      PARITY: begin
        if (clk_cnt == FULL) begin
          clk_cnt_d = '0;
          state_d   = STOP;
          if (rx_s != even_parity_bit(shift)) begin
            par_err   = 1'b1;
            par_bad_d = 1'b1;
          end
        end
      end
`endif
      STOP: begin
        if (clk_cnt == FULL) begin
          clk_cnt_d = '0;
          if (rx_s) begin
`ifdef UART_PARITY_EN
            byte_ok = ~par_bad;
`else
            byte_ok = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            frame_err = 1'b1;
            state_d   = BREAK;
          end
        end
      end
      // Line held low past the stop bit: wait for idle so the break is not read as a start.
      BREAK: begin
        clk_cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_program_loader.sv
// Serial program loader: UART bytes written to a 32x8 program store while Load is high.
// UART_PARITY_EN adds even-parity checking and the sticky PE flag.
module uart_program_loader
  import cpu8_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input logic               Clk,
  input logic               Reset,
  uart_program_loader_if.slave bus
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W:0]   wr_count;
  logic              load_q, load_rise, do_write;
  logic              fe;
  logic [DATA_W-1:0] rx_byte;
  logic              byte_ok, frame_err;
  rx_state_t         rx_state;
`ifdef UART_PARITY_EN
  logic              par_err, pe;
`endif

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk       (Clk),
    .rst       (Reset),
    .rx        (bus.RX),
    .rx_byte   (rx_byte),
    .byte_ok   (byte_ok),
    .frame_err (frame_err),
`ifdef UART_PARITY_EN
    .par_err   (par_err),
`endif
    .state     (rx_state)
  );

  // A Load rise restarts the program at address 0 and wins over a same-cycle write.
  assign load_rise = bus.Load & ~load_q;
  assign do_write  = byte_ok & bus.Load & ~load_rise;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= STORE_RESET;
      wr_ptr   <= '0;
      wr_count <= '0;
      load_q   <= 1'b0;
      fe       <= 1'b0;
`ifdef UART_PARITY_EN
      pe       <= 1'b0;
`endif
    end else begin
      load_q <= bus.Load;
      if (load_rise) begin
        wr_ptr   <= '0;
        wr_count <= '0;
        fe       <= 1'b0;
`ifdef UART_PARITY_EN
        pe       <= 1'b0;
`endif
      end else begin
        if (do_write) begin
          mem[wr_ptr] <= rx_byte;
          wr_ptr      <= wr_ptr + 1'b1;
          if (wr_count != (ADDR_W+1)'(DEPTH)) wr_count <= wr_count + 1'b1;
        end
        if (frame_err) fe <= 1'b1;
`ifdef UART_PARITY_EN
        if (par_err) pe <= 1'b1;
`endif
      end
    end
  end

  assign bus.data_out = mem[bus.PC];
  assign bus.FE       = fe;
  assign bus.wr_count = wr_count;
  assign bus.busy     = (rx_state != IDLE);
`ifdef UART_PARITY_EN
  assign bus.PE       = pe;
`endif

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized scoreboard bench for uart_program_loader; exercises parity when UART_PARITY_EN is defined.
`timescale 1ns/1ps
module tb_uart_program_loader;
  import cpu8_pkg::*;

  localparam int CPB = 16;
  localparam int EW  = 21; // {pe, fe, wr_count[5:0], pc[4:0], data[7:0]}

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_program_loader_if bus();

  uart_program_loader #(.CLKS_PER_BIT(CPB)) dut (
    .Clk   (clk),
    .Reset (rst),
    .bus   (bus.slave)
  );

  // reference model: store contents and flags from the behavioural rules
  logic [7:0] m_mem [32];
  int         m_ptr, m_cnt;
  bit         m_fe, m_pe;

  logic [EW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_mem[i] = 8'h00;
    m_ptr = 0; m_cnt = 0; m_fe = 0; m_pe = 0;
  endtask

  task automatic model_load_rise();
    m_ptr = 0; m_cnt = 0; m_fe = 0; m_pe = 0;
  endtask

  task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input bit load);
    bit good;
    good = stop_ok;
    if (!stop_ok) m_fe = 1;
`ifdef UART_PARITY_EN
    if (!par_ok) m_pe = 1;
    good = good && par_ok;
`else
    if (par_ok) good = good; // parity bit absent in 8N1
`endif
    if (good && load) begin
      m_mem[m_ptr] = d;
      m_ptr = (m_ptr + 1) % 32;
      if (m_cnt < 32) m_cnt++;
    end
  endtask

  task automatic push_expect(input int pc);
    exp_q.push_back({m_pe, m_fe, 6'(m_cnt), 5'(pc), m_mem[pc]});
  endtask

  // driver tasks
  task automatic set_load(input bit v);
    @(negedge clk);
    if (v && !bus.Load) model_load_rise();
    bus.Load = v;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_ok, input bit drop_load);
    int pc;
    @(negedge clk);
    pc = m_ptr;
    bus.PC = 5'(pc);
    model_frame(d, stop_ok, par_ok, drop_load ? 1'b0 : bus.Load);
    push_expect(pc);
    bus.RX = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      bus.RX = d[i];
      if (drop_load && i == 4) bus.Load = 1'b0;
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    bus.RX = (^d) ^ !par_ok;
    repeat (CPB) @(negedge clk);
`endif
    bus.RX = stop_ok;
    repeat (CPB) @(negedge clk);
    bus.RX = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_break(input int bits);
    @(negedge clk);
    bus.PC = 5'(m_ptr);
    model_frame(8'h00, 1'b0, 1'b1, bus.Load);
    push_expect(m_ptr);
    bus.RX = 1'b0;
    repeat (bits * CPB) @(negedge clk);
    bus.RX = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic send_glitch(input int cycles);
    @(negedge clk);
    bus.PC = 5'(m_ptr);
    push_expect(m_ptr);
    bus.RX = 1'b0;
    repeat (cycles) @(negedge clk);
    bus.RX = 1'b1;
    repeat (3 * CPB) @(negedge clk);
  endtask

  task automatic check_now(input string tag);
    @(negedge clk);
    check({tag, "_fe"}, bus.FE, m_fe);
    check({tag, "_wr_count"}, bus.wr_count, m_cnt);
    check({tag, "_busy"}, bus.busy, 0);
`ifdef UART_PARITY_EN
    check({tag, "_pe"}, bus.PE, m_pe);
`endif
  endtask

  // monitor: every end of a frame (busy falling) pops one expectation
  initial begin : monitor
    logic          prev_busy;
    logic [EW-1:0] e;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (prev_busy && !bus.busy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame actual=frame_end required=none at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("frame_wr_count", bus.wr_count, e[18:13]);
          check("frame_fe", bus.FE, e[19]);
          check("frame_data_out", bus.data_out, e[7:0]);
`ifdef UART_PARITY_EN
          check("frame_pe", bus.PE, e[20]);
`endif
        end
      end
      prev_busy = bus.busy;
    end
  end

  initial begin : stimulus
    int wait_cycles;
    bit lv;
    bus.RX = 1'b1;
    bus.Load = 1'b0;
    bus.PC = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_wr_count", bus.wr_count, 0);
    check("reset_fe", bus.FE, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_data_out", bus.data_out, 0);
    rst = 1'b0;

    // two good bytes into a fresh program
    set_load(1'b1);
    send_frame(8'h3A, 1'b1, 1'b1, 1'b0);
    send_frame(8'hE5, 1'b1, 1'b1, 1'b0);
    bus.PC = 5'd1;
    #1 check("pc1_data_out", bus.data_out, 8'hE5);

    // framing error, long break, then Load toggle clears FE
    send_frame(8'h55, 1'b0, 1'b1, 1'b0);
    send_break(40);
    check_now("after_break");
    set_load(1'b0);
    set_load(1'b1);
    check_now("load_toggle");

    // overfill: count saturates, pointer wraps
    for (int i = 0; i < 34; i++) send_frame(8'(i), 1'b1, 1'b1, 1'b0);
    check_now("saturate");

    // Load low drops the byte; a short low pulse is not a frame
    set_load(1'b0);
    send_frame(8'hFF, 1'b1, 1'b1, 1'b0);
    send_glitch(5);
    check_now("dropped");

    // Load falling mid-frame loses the byte
    set_load(1'b1);
    send_frame(8'h5C, 1'b1, 1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 1'b1, 1'b1);
    check_now("mid_drop");

    // randomized frames with random Load, bad stop and bad parity
    for (int n = 0; n < 16; n++) begin
      lv = ($urandom_range(0, 3) != 0);
      set_load(lv);
      send_frame(8'($urandom_range(0, 255)), $urandom_range(0, 7) != 0,
                 $urandom_range(0, 7) != 0, $urandom_range(0, 7) == 0);
    end

    // reset during data bit 4
    set_load(1'b1);
    @(negedge clk);
    bus.RX = 1'b0;
    repeat (CPB * 5 + CPB / 2) @(negedge clk);
    model_reset();
    bus.PC = '0;
    push_expect(0);
    @(posedge clk);
    #2 rst = 1'b1;
    bus.RX = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 32; i++) begin
      bus.PC = 5'(i);
      #1 check("reset_store", bus.data_out, 8'h00);
    end
    check_now("mid_reset");
    @(negedge clk);
    rst = 1'b0;
    bus.Load = 1'b0;
    set_load(1'b1);
    send_frame(8'h81, 1'b1, 1'b1, 1'b0);

`ifdef UART_PARITY_EN
    send_frame(8'h07, 1'b1, 1'b1, 1'b0);
    send_frame(8'h07, 1'b1, 1'b0, 1'b0);
    check_now("parity");
`endif

    // drain scoreboard with a bound
    wait_cycles = 0;
    while (exp_q.size() != 0 && wait_cycles < 2000) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
    end

    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.PC = 5'(i);
      #1 check($sformatf("store_%0d", i), bus.data_out, m_mem[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
